// File: rtl/dma_mc_pkg.sv
// Shared constants and types for the multi-channel DMA descriptor controller.
// Register word offsets, channel state encoding and STAT bit positions.
package dma_mc_pkg;

  localparam int unsigned A_START    = 32'h00;
  localparam int unsigned A_BUSY     = 32'h01;
  localparam int unsigned A_IRQ_EN   = 32'h02;
  localparam int unsigned A_IRQ_STAT = 32'h03;

  localparam int unsigned CH_BASE   = 32'h10;
  localparam int unsigned CH_STRIDE = 4;
  localparam int unsigned CH_ADDR   = 0;
  localparam int unsigned CH_BYTES  = 1;
  localparam int unsigned CH_TUSER  = 2;
  localparam int unsigned CH_STAT   = 3;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_ERR_LSB = 1;
  localparam int unsigned STAT_ERR_W   = 4;
  localparam int unsigned STAT_REJ     = 5;
  localparam int unsigned STAT_W       = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } chan_state_e;

  // Word address of register `off` in channel `c`.
  function automatic int unsigned ch_reg(input int unsigned c, input int unsigned off);
    return CH_BASE + CH_STRIDE * c + off;
  endfunction

endpackage

// File: rtl/dma_controller_mc_if.sv
// PS register port and datamover descriptor/status bundle for dma_controller_mc.
// The slave modport is the controller's view; master is the PS/datamover side.
interface dma_mc_if #(
  parameter int unsigned N_MM2S          = 3,
  parameter int unsigned N_S2MM          = 1,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_LEN_WIDTH   = 32,
  parameter int unsigned AXIS_USER_WIDTH = 65,
  parameter int unsigned AXI_TAG_WIDTH   = 8,
  parameter int unsigned REG_ADDR_WIDTH  = 8
);
  localparam int unsigned DESC_WIDTH = ADDR_WIDTH + AXI_LEN_WIDTH;

  logic                          reg_wr_en;
  logic                          reg_rd_en;
  logic [REG_ADDR_WIDTH-1:0]     reg_wr_addr;
  logic [REG_ADDR_WIDTH-1:0]     reg_rd_addr;
  logic [AXI_DATA_WIDTH-1:0]     reg_wr_data;
  logic [AXI_DATA_WIDTH-1:0]     reg_rd_data;

  logic [N_MM2S-1:0][DESC_WIDTH-1:0]      mm2s_desc;
  logic [N_MM2S-1:0][AXIS_USER_WIDTH-1:0] mm2s_user;
  logic [N_MM2S-1:0]                      mm2s_valid;
  logic [N_MM2S-1:0]                      mm2s_ready;
  logic [N_MM2S-1:0]                      mm2s_status_valid;
  logic [N_MM2S-1:0][3:0]                 mm2s_status_error;

  logic [N_S2MM-1:0][DESC_WIDTH-1:0]      s2mm_desc;
  logic [N_S2MM-1:0][AXI_TAG_WIDTH-1:0]   s2mm_tag;
  logic [N_S2MM-1:0]                      s2mm_valid;
  logic [N_S2MM-1:0]                      s2mm_ready;
  logic [N_S2MM-1:0]                      s2mm_status_valid;
  logic [N_S2MM-1:0][3:0]                 s2mm_status_error;

  logic                                   irq;

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_wr_addr, reg_rd_addr, reg_wr_data,
    input  mm2s_ready, mm2s_status_valid, mm2s_status_error,
    input  s2mm_ready, s2mm_status_valid, s2mm_status_error,
    output reg_rd_data, mm2s_desc, mm2s_user, mm2s_valid,
    output s2mm_desc, s2mm_tag, s2mm_valid, irq
  );

  modport master (
    output reg_wr_en, reg_rd_en, reg_wr_addr, reg_rd_addr, reg_wr_data,
    output mm2s_ready, mm2s_status_valid, mm2s_status_error,
    output s2mm_ready, s2mm_status_valid, s2mm_status_error,
    input  reg_rd_data, mm2s_desc, mm2s_user, mm2s_valid,
    input  s2mm_desc, s2mm_tag, s2mm_valid, irq
  );

endinterface

// File: rtl/dma_desc_channel.sv
// One DMA descriptor channel: IDLE/REQ/WAIT FSM, descriptor latch, STAT and tag counter.
// done_c_o is a same-cycle completion strobe used by the parent to set IRQ_STAT.
module dma_desc_channel
  import dma_mc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned USER_WIDTH = 65,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           cfg_addr_i,
  input  logic [LEN_WIDTH-1:0]            cfg_bytes_i,
  input  logic [USER_WIDTH-1:0]           cfg_user_i,
  input  logic                            ready_i,
  input  logic                            status_valid_i,
  input  logic [3:0]                      status_error_i,
  output logic [LEN_WIDTH+ADDR_WIDTH-1:0] desc_o,
  output logic [USER_WIDTH-1:0]           user_o,
  output logic [TAG_WIDTH-1:0]            tag_o,
  output logic                            valid_o,
  output logic                            busy_o,
  output logic [STAT_W-1:0]               stat_o,
  output logic                            done_c_o
);

  chan_state_e                     state_q, state_d;
  logic                            valid_q;
  logic [LEN_WIDTH+ADDR_WIDTH-1:0] desc_q;
  logic [USER_WIDTH-1:0]           user_q;
  logic [TAG_WIDTH-1:0]            tag_q, tag_cnt_q;
  logic                            done_q, rej_q;
  logic [STAT_ERR_W-1:0]           err_q;
  logic                            accept_c, hs_c;

  // Next-state logic and per-cycle event strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    hs_c     = 1'b0;
    done_c_o = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d  = REQ;
        accept_c = 1'b1;
      end
      REQ: if (ready_i) begin
        state_d = WAIT;
        hs_c    = 1'b1;
      end
      WAIT: if (status_valid_i) begin
        state_d  = IDLE;
        done_c_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      desc_q    <= '0;
      user_q    <= '0;
      tag_q     <= '0;
      tag_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
      rej_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == REQ);
      if (accept_c) begin
        desc_q <= {cfg_bytes_i, cfg_addr_i};
        user_q <= cfg_user_i;
        tag_q  <= tag_cnt_q;
        done_q <= 1'b0;
        err_q  <= '0;
        rej_q  <= 1'b0;
      end else if (start_i) begin
        rej_q <= 1'b1;
      end
      if (done_c_o) begin
        done_q <= 1'b1;
        err_q  <= status_error_i;
      end
      if (hs_c) begin
        tag_cnt_q <= tag_cnt_q + TAG_WIDTH'(1);
      end
    end
  end

  assign desc_o  = desc_q;
  assign user_o  = user_q;
  assign tag_o   = tag_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);
  assign stat_o  = {rej_q, err_q, done_q};

endmodule

// File: rtl/dma_controller_mc.sv
// Multi-channel DMA descriptor controller: PS register decode, START pulses,
// per-channel descriptor FSMs and the maskable level interrupt.
module dma_controller_mc
  import dma_mc_pkg::*;
#(
  parameter int unsigned N_MM2S          = 3,
  parameter int unsigned N_S2MM          = 1,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_LEN_WIDTH   = 32,
  parameter int unsigned AXIS_USER_WIDTH = 65,
  parameter int unsigned AXI_TAG_WIDTH   = 8,
  parameter int unsigned REG_ADDR_WIDTH  = 8
) (
  input  logic     clk,
  input  logic     rstn,
  dma_mc_if.slave  bus
);

  localparam int unsigned N_CH       = N_MM2S + N_S2MM;
  localparam int unsigned DESC_WIDTH = ADDR_WIDTH + AXI_LEN_WIDTH;

  logic [N_CH-1:0][ADDR_WIDTH-1:0]      cfg_addr_q;
  logic [N_CH-1:0][AXI_LEN_WIDTH-1:0]   cfg_bytes_q;
  logic [N_CH-1:0][AXI_DATA_WIDTH-1:0]  cfg_user_q;
  logic [N_CH-1:0]                      irq_en_q, irq_en_d;
  logic [N_CH-1:0]                      irq_stat_q, irq_stat_d;
  logic                                 irq_q;

  logic [N_CH-1:0]                      start_c, w1c_c, busy, done_c;
  logic [N_CH-1:0]                      ch_ready, ch_sv, ch_valid;
  logic [N_CH-1:0][3:0]                 ch_err;
  logic [N_CH-1:0][DESC_WIDTH-1:0]      ch_desc;
  logic [N_CH-1:0][AXIS_USER_WIDTH-1:0] ch_user;
  logic [N_CH-1:0][AXI_TAG_WIDTH-1:0]   ch_tag;
  logic [N_CH-1:0][STAT_W-1:0]          ch_stat;
  logic [AXI_DATA_WIDTH-1:0]            rd_c;
  logic                                 wr_start_c, wr_irq_en_c, wr_irq_stat_c;

  assign wr_start_c    = bus.reg_wr_en && (bus.reg_wr_addr == REG_ADDR_WIDTH'(A_START));
  assign wr_irq_en_c   = bus.reg_wr_en && (bus.reg_wr_addr == REG_ADDR_WIDTH'(A_IRQ_EN));
  assign wr_irq_stat_c = bus.reg_wr_en && (bus.reg_wr_addr == REG_ADDR_WIDTH'(A_IRQ_STAT));

  assign start_c = wr_start_c    ? bus.reg_wr_data[N_CH-1:0] : '0;
  assign w1c_c   = wr_irq_stat_c ? bus.reg_wr_data[N_CH-1:0] : '0;

  // A completion in the same cycle as a W1C keeps the bit set.
  assign irq_en_d   = wr_irq_en_c ? bus.reg_wr_data[N_CH-1:0] : irq_en_q;
  assign irq_stat_d = (irq_stat_q & ~w1c_c) | done_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_addr_q  <= '0;
      cfg_bytes_q <= '0;
      cfg_user_q  <= '0;
      irq_en_q    <= '0;
      irq_stat_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= |(irq_stat_d & irq_en_d);
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (bus.reg_wr_en && (bus.reg_wr_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_ADDR))))
          cfg_addr_q[c] <= ADDR_WIDTH'(bus.reg_wr_data);
        if (bus.reg_wr_en && (bus.reg_wr_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_BYTES))))
          cfg_bytes_q[c] <= AXI_LEN_WIDTH'(bus.reg_wr_data);
        if ((c < N_MM2S) && bus.reg_wr_en &&
            (bus.reg_wr_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_TUSER))))
          cfg_user_q[c] <= bus.reg_wr_data;
      end
    end
  end

  // Combinational read mux; unmapped addresses and START read as zero.
  always_comb begin
    rd_c = '0;
    if (bus.reg_rd_addr == REG_ADDR_WIDTH'(A_BUSY))     rd_c = AXI_DATA_WIDTH'(busy);
    if (bus.reg_rd_addr == REG_ADDR_WIDTH'(A_IRQ_EN))   rd_c = AXI_DATA_WIDTH'(irq_en_q);
    if (bus.reg_rd_addr == REG_ADDR_WIDTH'(A_IRQ_STAT)) rd_c = AXI_DATA_WIDTH'(irq_stat_q);
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (bus.reg_rd_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_ADDR)))
        rd_c = AXI_DATA_WIDTH'(cfg_addr_q[c]);
      if (bus.reg_rd_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_BYTES)))
        rd_c = AXI_DATA_WIDTH'(cfg_bytes_q[c]);
      if (bus.reg_rd_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_TUSER)))
        rd_c = cfg_user_q[c];
      if (bus.reg_rd_addr == REG_ADDR_WIDTH'(ch_reg(c, CH_STAT)))
        rd_c = AXI_DATA_WIDTH'(ch_stat[c]);
    end
  end

  assign ch_ready = {bus.s2mm_ready, bus.mm2s_ready};
  assign ch_sv    = {bus.s2mm_status_valid, bus.mm2s_status_valid};
  assign ch_err   = {bus.s2mm_status_error, bus.mm2s_status_error};

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    dma_desc_channel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (AXI_LEN_WIDTH),
      .USER_WIDTH (AXIS_USER_WIDTH),
      .TAG_WIDTH  (AXI_TAG_WIDTH)
    ) u_ch (
      .clk            (clk),
      .rstn           (rstn),
      .start_i        (start_c[c]),
      .cfg_addr_i     (cfg_addr_q[c]),
      .cfg_bytes_i    (cfg_bytes_q[c]),
      .cfg_user_i     (AXIS_USER_WIDTH'(cfg_user_q[c])),
      .ready_i        (ch_ready[c]),
      .status_valid_i (ch_sv[c]),
      .status_error_i (ch_err[c]),
      .desc_o         (ch_desc[c]),
      .user_o         (ch_user[c]),
      .tag_o          (ch_tag[c]),
      .valid_o        (ch_valid[c]),
      .busy_o         (busy[c]),
      .stat_o         (ch_stat[c]),
      .done_c_o       (done_c[c])
    );
  end

  assign bus.reg_rd_data = rd_c;
  assign bus.mm2s_desc   = ch_desc[N_MM2S-1:0];
  assign bus.mm2s_user   = ch_user[N_MM2S-1:0];
  assign bus.mm2s_valid  = ch_valid[N_MM2S-1:0];
  assign bus.s2mm_desc   = ch_desc[N_CH-1:N_MM2S];
  assign bus.s2mm_tag    = ch_tag[N_CH-1:N_MM2S];
  assign bus.s2mm_valid  = ch_valid[N_CH-1:N_MM2S];
  assign bus.irq         = irq_q;

  // Read strobe, S2MM tuser and MM2S tags have no consumer.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.reg_rd_en, ch_user[N_CH-1:N_MM2S], ch_tag[N_MM2S-1:0]};

endmodule

// File: doc/dma_controller_mc.md
Name: dma_controller_mc

Overview:
- Parametrised multi-channel DMA descriptor controller: N_MM2S read channels and N_S2MM write channels, each driven by a per-channel descriptor FSM.
- Sits between the PS register port and the datamover descriptor/status interfaces.
- Channels start independently, descriptors are latched at start, completion and error status are captured per channel, and a maskable level interrupt is raised.

Parameters:
- N_MM2S, 3, number of MM2S channels (1..8)
- N_S2MM, 1, number of S2MM channels (1..8)
- ADDR_WIDTH, 32, memory address width
- AXI_DATA_WIDTH, 32, register data width (>= N_MM2S+N_S2MM)
- AXI_LEN_WIDTH, 32, byte-count width
- AXIS_USER_WIDTH, 65, MM2S tuser width
- AXI_TAG_WIDTH, 8, S2MM tag width
- REG_ADDR_WIDTH, 8, register word-address width
- DESC_WIDTH (localparam), ADDR_WIDTH+AXI_LEN_WIDTH, descriptor = {len, addr}

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- reg_wr_en, reg_rd_en  in  1  PS register strobes
- reg_wr_addr, reg_rd_addr  in  REG_ADDR_WIDTH  word addresses
- reg_wr_data  in  AXI_DATA_WIDTH  write data
- reg_rd_data  out  AXI_DATA_WIDTH  combinational read data
- mm2s_desc  out  [N_MM2S][DESC_WIDTH]  MM2S descriptor per channel
- mm2s_user  out  [N_MM2S][AXIS_USER_WIDTH]  tuser per channel
- mm2s_valid  out  [N_MM2S]  descriptor valid
- mm2s_ready  in  [N_MM2S]  descriptor ready
- mm2s_status_valid  in  [N_MM2S]  completion strobe
- mm2s_status_error  in  [N_MM2S][4]  completion error code
- s2mm_desc  out  [N_S2MM][DESC_WIDTH]  S2MM descriptor
- s2mm_tag  out  [N_S2MM][AXI_TAG_WIDTH]  per-channel tag
- s2mm_valid  out  [N_S2MM]  descriptor valid
- s2mm_ready  in  [N_S2MM]  descriptor ready
- s2mm_status_valid  in  [N_S2MM]  completion strobe
- s2mm_status_error  in  [N_S2MM][4]  completion error code
- irq  out  1  level interrupt, = |(IRQ_STAT & IRQ_EN)

Behaviour:
- Channel index c: MM2S channels are 0..N_MM2S-1; S2MM channel k is c = N_MM2S+k.
- Register map, global:
  - 0x00 START: W1S pulse, bit c starts channel c; reads 0.
  - 0x01 BUSY: RO, bit c = channel c not IDLE.
  - 0x02 IRQ_EN: RW.
  - 0x03 IRQ_STAT: W1C.
- Register map, per channel at base 0x10+4c: +0 ADDR, +1 BYTES, +2 TUSER (MM2S only, zero-extended to AXIS_USER_WIDTH; reads 0 for S2MM), +3 STAT (RO: bit0 done, bits4:1 error, bit5 rejected-start).
- Unmapped addresses read 0 and ignore writes.
- Per-channel FSM has states IDLE, REQ, WAIT:
  - IDLE→REQ on START bit c. In the same cycle, latch {BYTES, ADDR, TUSER} into the output descriptor registers and clear STAT.
  - REQ: valid=1 with descriptor held stable; →WAIT on the cycle valid&&ready.
  - WAIT: →IDLE on status_valid. Set STAT.done=1 and STAT.error=status_error, and set IRQ_STAT[c].
- Outputs are registered. mm2s_valid/s2mm_valid rise the cycle after the START write.
- PS writes to ADDR/BYTES/TUSER during REQ/WAIT update only the config registers; the in-flight descriptor does not change.
- START bit c while channel c is not IDLE: ignored, and STAT.rejected=1 (sticky until the next accepted start).
- status_valid in IDLE or REQ: ignored.
- s2mm_tag: per-channel counter, reset 0, latched into the tag output at start and incremented on each accepted descriptor; wraps modulo 2^AXI_TAG_WIDTH.
- Simultaneous W1C of IRQ_STAT[c] and hardware set of IRQ_STAT[c] in the same cycle: set wins.
- Several START bits in one write: all addressed IDLE channels start in the same cycle; there is no arbitration.
- Reset values (asynchronous, any state): all FSMs IDLE; all valids 0; desc/user/tag 0; all registers 0; irq 0. A transfer in flight at reset is abandoned, and any later status strobes are ignored.
- reg_rd_data is combinational on reg_rd_addr; reg_rd_en is unused.

Decomposition:
- Package dma_mc_pkg holds:
  - register offset constants (A_START, A_BUSY, A_IRQ_EN, A_IRQ_STAT, CH_BASE, CH_STRIDE, CH_ADDR/BYTES/TUSER/STAT offsets);
  - the chan_state_e enum {IDLE, REQ, WAIT};
  - STAT bit-position constants.
- Sub-module dma_desc_channel: one FSM, descriptor latch, STAT and tag counter (tag output unused for MM2S). Instantiated N_MM2S+N_S2MM times with a generate loop.
- The top level decodes registers, builds START pulses, and assembles IRQ_STAT.

Test Plan:
- Single MM2S ch0, write ADDR=0x1000, BYTES=0x40, START=0x1, ready=1 → mm2s_valid[0] high exactly 1 cycle with desc={0x40,0x1000}; status_valid with error 0 → STAT0=0x1, IRQ_STAT bit0=1, irq=1 only if IRQ_EN[0]=1.
- Backpressure: s2mm_ready=0 for 5 cycles after START bit 3 (N_MM2S=3) → valid held 5+1 cycles with desc stable despite a PS rewrite of ADDR mid-REQ; BUSY[3]=1 throughout.
- Error plus W1C race: status_error=4'h3 → STAT.error=3; W1C IRQ_STAT in the same cycle as a new completion → bit stays 1.
- Rejected start: START bit0 while ch0 in WAIT → no new valid, STAT0.rejected=1; next start after completion accepted and rejected cleared.
- Tag wrap: AXI_TAG_WIDTH=2, run 5 S2MM transfers → tags 0,1,2,3,0.
- Async reset asserted during WAIT (mid-cycle) → all valids/irq 0 immediately; a late status_valid after reset causes no STAT/IRQ change.
